// File: rtl/wbu_commit_if.sv
// LSU -> write-back handshake bundle: one finished instruction per valid/ready transfer.
interface wbu_commit_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CSR_AW = 12
) ();

  logic              valid;
  logic              ready;
  logic [XLEN-1:0]   pc;
  logic              reg_wen;
  logic [REG_AW-1:0] reg_waddr;
  logic [XLEN-1:0]   reg_wdata;
  logic              csr_wen;
  logic [CSR_AW-1:0] csr_wid;
  logic [XLEN-1:0]   csr_wdata;
  logic              is_ecall;
  logic [XLEN-1:0]   mcause;

  // LSU side: produces the instruction, observes ready
  modport master (
    output valid, pc, reg_wen, reg_waddr, reg_wdata,
           csr_wen, csr_wid, csr_wdata, is_ecall, mcause,
    input  ready
  );

  // Write-back side: consumes the instruction, drives ready
  modport slave (
    input  valid, pc, reg_wen, reg_waddr, reg_wdata,
           csr_wen, csr_wid, csr_wdata, is_ecall, mcause,
    output ready
  );

endinterface

// File: rtl/wbu_commit.sv
// Write-back/commit stage: latches one instruction from the LSU, then spends exactly one
// COMMIT cycle pulsing GPR / CSR / ecall / done strobes from the latched copy.
// Optional feature macro: WBU_INSTRET_EN builds the 64-bit retired-instruction counter;
// when undefined o_instret is tied to zero.
module wbu_commit #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CSR_AW = 12
) (
  input  logic              clk,
  input  logic              rst,
  wbu_commit_if.slave       lsu,
  output logic              o_reg_wen,
  output logic [REG_AW-1:0] o_reg_waddr,
  output logic [XLEN-1:0]   o_reg_wdata,
  output logic              o_ccu_csr_wen,
  output logic [CSR_AW-1:0] o_ccu_csr_wid,
  output logic [XLEN-1:0]   o_ccu_csr_rd,
  output logic              o_ccu_is_ecall,
  output logic [XLEN-1:0]   o_ccu_macuse_in,
  output logic [XLEN-1:0]   o_ccu_mepc_in,
  output logic              o_ifu_done,
  output logic [XLEN-1:0]   o_commit_pc,
  output logic [63:0]       o_instret
);

  localparam int unsigned CNT_W = 64;

  typedef enum logic {
    IDLE   = 1'b0,
    COMMIT = 1'b1
  } state_t;

  state_t state;
  logic   ready_q;

  assign lsu.ready = ready_q;

  // Commit FSM; strobes are loaded at the handshake so they appear during COMMIT,
  // data outputs keep their last latched value once the strobes drop
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      ready_q         <= 1'b1;
      o_reg_wen       <= 1'b0;
      o_reg_waddr     <= '0;
      o_reg_wdata     <= '0;
      o_ccu_csr_wen   <= 1'b0;
      o_ccu_csr_wid   <= '0;
      o_ccu_csr_rd    <= '0;
      o_ccu_is_ecall  <= 1'b0;
      o_ccu_macuse_in <= '0;
      o_ccu_mepc_in   <= '0;
      o_ifu_done      <= 1'b0;
      o_commit_pc     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (lsu.valid && ready_q) begin
            state           <= COMMIT;
            ready_q         <= 1'b0;
            // x0 is hard-wired zero, so its writes never reach the GPR file
            o_reg_wen       <= lsu.reg_wen && (lsu.reg_waddr != '0);
            o_reg_waddr     <= lsu.reg_waddr;
            o_reg_wdata     <= lsu.reg_wdata;
            // ecall wins over any CSR write carried by the same instruction
            o_ccu_csr_wen   <= lsu.csr_wen && !lsu.is_ecall;
            o_ccu_csr_wid   <= lsu.csr_wid;
            o_ccu_csr_rd    <= lsu.csr_wdata;
            o_ccu_is_ecall  <= lsu.is_ecall;
            o_ccu_macuse_in <= lsu.mcause;
            o_ccu_mepc_in   <= lsu.pc;
            o_ifu_done      <= 1'b1;
            o_commit_pc     <= lsu.pc;
          end
        end
        COMMIT: begin
          state          <= IDLE;
          ready_q        <= 1'b1;
          o_reg_wen      <= 1'b0;
          o_ccu_csr_wen  <= 1'b0;
          o_ccu_is_ecall <= 1'b0;
          o_ifu_done     <= 1'b0;
        end
        default: begin
          state          <= IDLE;
          ready_q        <= 1'b1;
          o_reg_wen      <= 1'b0;
          o_ccu_csr_wen  <= 1'b0;
          o_ccu_is_ecall <= 1'b0;
          o_ifu_done     <= 1'b0;
        end
      endcase
    end
  end

`ifdef WBU_INSTRET_EN
  logic [CNT_W-1:0] instret_q;

  // Count every COMMIT cycle that completes without reset; wraps naturally at 2^64
  always_ff @(posedge clk) begin
    if (rst) begin
      instret_q <= '0;
    end else if (state == COMMIT) begin
      instret_q <= instret_q + CNT_W'(1);
    end
  end

  assign o_instret = instret_q;
`else
  assign o_instret = CNT_W'(0);
`endif

endmodule

// File: tb/tb_wbu_commit.sv
// Directed self-checking bench for wbu_commit (default build and WBU_INSTRET_EN build).
module tb_wbu_commit;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned CSR_AW = 12;

  logic              clk;
  logic              rst;
  logic              o_reg_wen;
  logic [REG_AW-1:0] o_reg_waddr;
  logic [XLEN-1:0]   o_reg_wdata;
  logic              o_ccu_csr_wen;
  logic [CSR_AW-1:0] o_ccu_csr_wid;
  logic [XLEN-1:0]   o_ccu_csr_rd;
  logic              o_ccu_is_ecall;
  logic [XLEN-1:0]   o_ccu_macuse_in;
  logic [XLEN-1:0]   o_ccu_mepc_in;
  logic              o_ifu_done;
  logic [XLEN-1:0]   o_commit_pc;
  logic [63:0]       o_instret;

  int tests_run;
  int tests_failed;
  int done_cnt;

`ifdef WBU_INSTRET_EN
  localparam logic [63:0] EXP_CNT_MAIN  = 64'd9;
  localparam logic [63:0] EXP_CNT_AFTER = 64'd1;
`else
  localparam logic [63:0] EXP_CNT_MAIN  = 64'd0;
  localparam logic [63:0] EXP_CNT_AFTER = 64'd0;
`endif

  wbu_commit_if #(.XLEN(XLEN), .REG_AW(REG_AW), .CSR_AW(CSR_AW)) lsu ();

  wbu_commit #(.XLEN(XLEN), .REG_AW(REG_AW), .CSR_AW(CSR_AW)) dut (
    .clk             (clk),
    .rst             (rst),
    .lsu             (lsu.slave),
    .o_reg_wen       (o_reg_wen),
    .o_reg_waddr     (o_reg_waddr),
    .o_reg_wdata     (o_reg_wdata),
    .o_ccu_csr_wen   (o_ccu_csr_wen),
    .o_ccu_csr_wid   (o_ccu_csr_wid),
    .o_ccu_csr_rd    (o_ccu_csr_rd),
    .o_ccu_is_ecall  (o_ccu_is_ecall),
    .o_ccu_macuse_in (o_ccu_macuse_in),
    .o_ccu_mepc_in   (o_ccu_mepc_in),
    .o_ifu_done      (o_ifu_done),
    .o_commit_pc     (o_commit_pc),
    .o_instret       (o_instret)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; sample point is 1 ns after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an instruction on the LSU side with valid asserted
  task automatic drive(input logic [31:0] pc, input logic rwen, input logic [4:0] waddr,
                       input logic [31:0] wdata, input logic cwen, input logic [11:0] wid,
                       input logic [31:0] cdata, input logic ecall, input logic [31:0] cause);
    lsu.valid     = 1'b1;
    lsu.pc        = pc;
    lsu.reg_wen   = rwen;
    lsu.reg_waddr = waddr;
    lsu.reg_wdata = wdata;
    lsu.csr_wen   = cwen;
    lsu.csr_wid   = wid;
    lsu.csr_wdata = cdata;
    lsu.is_ecall  = ecall;
    lsu.mcause    = cause;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    done_cnt     = 0;
    rst          = 1'b1;
    drive(32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 12'h0, 32'h0, 1'b0, 32'h0);
    lsu.valid = 1'b0;

    // Reset state
    step();
    step();
    check("rst_ready",   64'(lsu.ready),      64'd1);
    check("rst_reg_wen", 64'(o_reg_wen),      64'd0);
    check("rst_csr_wen", 64'(o_ccu_csr_wen),  64'd0);
    check("rst_ecall",   64'(o_ccu_is_ecall), 64'd0);
    check("rst_done",    64'(o_ifu_done),     64'd0);
    check("rst_wdata",   64'(o_reg_wdata),    64'd0);
    check("rst_instret", o_instret,           64'd0);
    rst = 1'b0;
    step();

    // Plain GPR write
    drive(32'h8000_0000, 1'b1, 5'd5, 32'h0000_1234, 1'b0, 12'h0, 32'h0, 1'b0, 32'h0);
    step();
    lsu.valid = 1'b0;
    check("gpr_reg_wen", 64'(o_reg_wen),   64'd1);
    check("gpr_waddr",   64'(o_reg_waddr), 64'd5);
    check("gpr_wdata",   64'(o_reg_wdata), 64'h1234);
    check("gpr_done",    64'(o_ifu_done),  64'd1);
    check("gpr_pc",      64'(o_commit_pc), 64'h8000_0000);
    check("gpr_ready",   64'(lsu.ready),   64'd0);
    step();
    check("idle_done",    64'(o_ifu_done),  64'd0);
    check("idle_reg_wen", 64'(o_reg_wen),   64'd0);
    check("idle_ready",   64'(lsu.ready),   64'd1);
    check("idle_wdata",   64'(o_reg_wdata), 64'h1234);
    check("idle_pc",      64'(o_commit_pc), 64'h8000_0000);

    // Write to x0 suppressed
    drive(32'h8000_0004, 1'b1, 5'd0, 32'h0000_FFFF, 1'b0, 12'h0, 32'h0, 1'b0, 32'h0);
    step();
    lsu.valid = 1'b0;
    check("x0_reg_wen", 64'(o_reg_wen),   64'd0);
    check("x0_done",    64'(o_ifu_done),  64'd1);
    check("x0_wdata",   64'(o_reg_wdata), 64'hFFFF);
    step();

    // CSR write
    drive(32'h8000_0008, 1'b0, 5'd0, 32'h0, 1'b1, 12'h305, 32'h8000_1000, 1'b0, 32'h0);
    step();
    lsu.valid = 1'b0;
    check("csr_wen",     64'(o_ccu_csr_wen),  64'd1);
    check("csr_wid",     64'(o_ccu_csr_wid),  64'h305);
    check("csr_rd",      64'(o_ccu_csr_rd),   64'h8000_1000);
    check("csr_ecall",   64'(o_ccu_is_ecall), 64'd0);
    check("csr_reg_wen", 64'(o_reg_wen),      64'd0);
    step();
    check("csr_idle_wen", 64'(o_ccu_csr_wen), 64'd0);

    // ecall overrides CSR write, GPR write still honoured
    drive(32'h8000_0040, 1'b1, 5'd10, 32'hCAFE_0001, 1'b1, 12'h300, 32'h1, 1'b1, 32'd11);
    step();
    lsu.valid = 1'b0;
    check("ecall_strobe",  64'(o_ccu_is_ecall),  64'd1);
    check("ecall_csr_wen", 64'(o_ccu_csr_wen),   64'd0);
    check("ecall_mcause",  64'(o_ccu_macuse_in), 64'd11);
    check("ecall_mepc",    64'(o_ccu_mepc_in),   64'h8000_0040);
    check("ecall_reg_wen", 64'(o_reg_wen),       64'd1);
    check("ecall_waddr",   64'(o_reg_waddr),     64'd10);
    step();
    check("ecall_idle", 64'(o_ccu_is_ecall), 64'd0);

    // valid held 10 cycles: ready alternates, 5 commits
    drive(32'h8000_0100, 1'b1, 5'd7, 32'h0000_0077, 1'b0, 12'h0, 32'h0, 1'b0, 32'h0);
    for (int k = 1; k <= 10; k++) begin
      step();
      check("stream_ready", 64'(lsu.ready), (k % 2 == 0) ? 64'd1 : 64'd0);
      if (o_ifu_done) done_cnt++;
    end
    lsu.valid = 1'b0;
    check("stream_commits", 64'(done_cnt), 64'd5);
    check("instret_main",   o_instret,     EXP_CNT_MAIN);

    // Reset on the handshake edge: instruction dropped
    drive(32'h8000_0200, 1'b1, 5'd3, 32'h0000_0033, 1'b0, 12'h0, 32'h0, 1'b0, 32'h0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    lsu.valid = 1'b0;
    check("rsths_reg_wen", 64'(o_reg_wen),  64'd0);
    check("rsths_done",    64'(o_ifu_done), 64'd0);
    check("rsths_ready",   64'(lsu.ready),  64'd1);
    check("rsths_instret", o_instret,       64'd0);
    step();
    check("rsths_after_done", 64'(o_ifu_done), 64'd0);

    // Reset during COMMIT: not counted, strobes cleared
    drive(32'h8000_0300, 1'b1, 5'd4, 32'h0000_0044, 1'b0, 12'h0, 32'h0, 1'b0, 32'h0);
    step();
    lsu.valid = 1'b0;
    check("rstc_in_commit", 64'(o_ifu_done), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rstc_done",    64'(o_ifu_done), 64'd0);
    check("rstc_reg_wen", 64'(o_reg_wen),  64'd0);
    check("rstc_ready",   64'(lsu.ready),  64'd1);
    check("rstc_instret", o_instret,       64'd0);

    // One commit after reset
    drive(32'h8000_0400, 1'b1, 5'd9, 32'h0000_0099, 1'b0, 12'h0, 32'h0, 1'b0, 32'h0);
    step();
    lsu.valid = 1'b0;
    check("post_done", 64'(o_ifu_done),  64'd1);
    check("post_pc",   64'(o_commit_pc), 64'h8000_0400);
    step();
    check("post_instret", o_instret, EXP_CNT_AFTER);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
